// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment display blocks.
//   seg_t      - 7-bit active-low cathode vector {g,f,e,d,c,b,a}
//   SEG_TABLE  - glyphs for nibble values 0..F
//   SEG_OFF    - all segments dark
//   MAX_HEX / MAX_DEC - per-digit maximum in hex / decimal mode
//   clamp_dec  - limits a nibble to 9 for decimal mode
package seg_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_DEC = 1'b1
  } count_mode_e;

  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam seg_t       SEG_OFF = 7'h7F;
  localparam logic [3:0] MAX_HEX = 4'hF;
  localparam logic [3:0] MAX_DEC = 4'd9;

  function automatic logic [3:0] clamp_dec(input logic [3:0] n);
    return (n > MAX_DEC) ? MAX_DEC : n;
  endfunction

endpackage

// File: rtl/seg_counter_mux_if.sv
// seg_counter_mux_if: control inputs and display outputs of seg_counter_mux.
//   EN, UP, MODE, LOAD, LOAD_VAL - count control (driven by master)
//   Count, Wrap, Anode, Out      - counter value and display pins (driven by slave)
// The counter itself uses the slave modport; the board/bench side uses master.
interface seg_counter_mux_if #(
  parameter int DIGITS = 4
);

  logic                  EN;
  logic                  UP;
  logic                  MODE;
  logic                  LOAD;
  logic [4*DIGITS-1:0]   LOAD_VAL;
  logic [4*DIGITS-1:0]   Count;
  logic                  Wrap;
  logic [DIGITS-1:0]     Anode;
  logic [6:0]            Out;

  modport master (
    output EN, UP, MODE, LOAD, LOAD_VAL,
    input  Count, Wrap, Anode, Out
  );

  modport slave (
    input  EN, UP, MODE, LOAD, LOAD_VAL,
    output Count, Wrap, Anode, Out
  );

endinterface

// File: rtl/seg_digit_decode.sv
// seg_digit_decode: nibble to active-low seven-segment cathodes.
//   nibble - digit value 0..F
//   blank  - 1 forces all segments off
//   seg    - cathodes {g,f,e,d,c,b,a}, active low
// Purely combinational.
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = blank ? SEG_OFF : SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg_counter_mux.sv
// seg_counter_mux: multi-digit hex/decimal up/down counter driving a
// multiplexed seven-segment display.
//   CLK - system clock, rising edge
//   RST - asynchronous active-high reset
//   bus - seg_counter_mux_if.slave:
//         EN, UP, MODE, LOAD, LOAD_VAL in; Count, Wrap, Anode, Out out
// Count advances once every TICK_DIV enabled cycles; the display scan
// rotates one digit every SCAN_DIV cycles regardless of EN.
module seg_counter_mux
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 262144,
  parameter int BLANK_LZ = 0
) (
  input logic               CLK,
  input logic               RST,
  seg_counter_mux_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  count_mode_e       mode;
  logic [PW-1:0]     pre;
  logic              tick;
  logic [W-1:0]      count_q;
  logic [W-1:0]      count_nxt;
  logic [W-1:0]      load_val;
  logic [DIGITS:0]   carry;
  logic [DIGITS:0]   zero_above;
  logic [DIGITS-1:0] blank;
  logic              wrap_q;

  logic [SW-1:0]     scan_cnt;
  logic [IW-1:0]     scan_idx;
  logic [3:0]        cur_nib;
  logic              cur_blank;
  seg_t              cur_seg;
  logic [DIGITS-1:0] anode_q;
  seg_t              out_q;

  assign mode = count_mode_e'(bus.MODE);
  assign tick = bus.EN && (pre == PW'(TICK_DIV - 1));

  // carry[k] means digit k steps this tick; it ripples up while digits sit at
  // their limit, so carry[DIGITS] flags a full-range wrap.
  assign carry[0]           = 1'b1;
  assign zero_above[DIGITS] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] d;
    logic [3:0] d_eff;
    logic [3:0] d_max;
    logic [3:0] d_nxt;
    logic       at_lim;

    assign d      = count_q[4*k +: 4];
    assign d_max  = (mode == MODE_DEC) ? MAX_DEC : MAX_HEX;
    // A stale hex nibble (>9) after switching to decimal behaves as 9.
    assign d_eff  = (mode == MODE_DEC) ? clamp_dec(d) : d;
    assign at_lim = bus.UP ? (d_eff == d_max) : (d_eff == 4'd0);

    always_comb begin
      d_nxt = d;
      if (carry[k]) begin
        if (at_lim) d_nxt = bus.UP ? 4'd0 : d_max;
        else        d_nxt = bus.UP ? d_eff + 4'd1 : d_eff - 4'd1;
      end
    end

    assign carry[k+1]          = carry[k] & at_lim;
    assign count_nxt[4*k +: 4] = d_nxt;
    assign load_val[4*k +: 4]  = (mode == MODE_DEC) ? clamp_dec(bus.LOAD_VAL[4*k +: 4])
                                                    : bus.LOAD_VAL[4*k +: 4];

    // Leading-zero blanking: this digit and everything above it are zero.
    assign zero_above[k] = (d == 4'd0) && zero_above[k+1];
    assign blank[k]      = (BLANK_LZ != 0) && (k > 0) && zero_above[k];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      pre     <= '0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.LOAD) begin
        count_q <= load_val;
        pre     <= '0;
      end else if (bus.EN) begin
        if (tick) begin
          pre     <= '0;
          count_q <= count_nxt;
          wrap_q  <= carry[DIGITS];
        end else begin
          pre <= pre + 1'b1;
        end
      end
    end
  end

  assign cur_nib   = count_q[{scan_idx, 2'b00} +: 4];
  assign cur_blank = blank[scan_idx];

  seg_digit_decode u_decode (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .seg    (cur_seg)
  );

  // Anode/Out refresh every cycle so a count change shows on the lit digit
  // one cycle later, not only at the next scan step.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      anode_q  <= '1;
      out_q    <= SEG_OFF;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      anode_q <= cur_blank ? '1 : ~(DIGITS'(1) << scan_idx);
      out_q   <= cur_seg;
    end
  end

  assign bus.Count = count_q;
  assign bus.Wrap  = wrap_q;
  assign bus.Anode = anode_q;
  assign bus.Out   = out_q;

endmodule

// File: doc/seg_counter_mux.md
Name: seg_counter_mux

Overview:
- Parametrised multi-digit up/down counter with multiplexed seven-segment scan output.
- Successor to the single-nibble board display counter. Adds:
  - configurable digit count and rates;
  - hex/decimal mode;
  - count direction;
  - synchronous load;
  - leading-zero blanking;
  - wrap flag;
  - an asynchronous reset.
- Sits between board switches/buttons and the anode/cathode pins of the on-board display.

Parameters:
- DIGITS, 4, number of displayed digits (1..8); count width = 4*DIGITS.
- TICK_DIV, 100000000, CLK cycles per count step (>=2).
- SCAN_DIV, 262144, CLK cycles each digit is lit before the scan advances (>=2).
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 never blanked).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  count enable; low freezes the prescaler and the count.
- UP  input  1  1 = count up, 0 = count down; sampled on the tick cycle.
- MODE  input  1  0 = hex digits (0..F), 1 = decimal digits (0..9).
- LOAD  input  1  synchronous load strobe.
- LOAD_VAL  input  4*DIGITS  value for LOAD; nibble k = digit k, digit 0 least significant.
- Count  output  4*DIGITS  current count, registered.
- Wrap  output  1  one-cycle pulse on full-range wrap.
- Anode  output  DIGITS  active-low digit select, bit k = digit k, registered.
- Out  output  7  active-low cathodes {g,f,e,d,c,b,a}, registered.

Behaviour:
Reset (RST high, asynchronous):
- Count = 0, Wrap = 0.
- Anode = all 1s, Out = 7'b1111111.
- Prescaler = 0, scan counter = 0, scan index = 0.
- Reset mid-count or mid-scan aborts immediately; the first tick after release occurs TICK_DIV enabled cycles later.

Prescaler:
- With EN=1, counts 0..TICK_DIV-1 and then returns to 0.
- tick = 1 in the cycle the prescaler equals TICK_DIV-1 and EN=1.
- With EN=0, the prescaler holds its value.

Count update, priority LOAD > tick:
- LOAD=1: Count <= LOAD_VAL next cycle, and the prescaler clears to 0.
  - In MODE=1, any loaded nibble >9 is stored as 9.
  - LOAD works regardless of EN.
- tick and UP=1: digit 0 increments. A digit at its maximum (F hex / 9 decimal) goes to 0 and carries into the next digit.
- tick and UP=0: digit 0 decrements. A digit at 0 goes to its maximum and borrows from the next digit.
- Full wrap: all digits go max->0 (up) or 0->max (down). Wrap = 1 for exactly the cycle after that tick, otherwise 0.
- A MODE change takes effect on the next tick. Existing nibbles >9 in decimal mode are treated as 9 for the carry decision, then follow the normal rules.

Scan:
- The scan counter runs 0..SCAN_DIV-1 continuously, independent of EN.
- At its terminal value, the scan index advances; after DIGITS-1 it returns to 0.
- One cycle after each index change:
  - Anode = ~(1 << index).
  - Out = segment pattern of Count nibble[index].
- Segment patterns, 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
- Out and Anode are updated every cycle from the current index and Count, so a count change shows within 1 cycle on the lit digit.

Blanking:
- With BLANK_LZ=1, digit k>0 is blanked when it and all higher digits are 0.
- A blanked digit drives Anode bit k = 1 and Out = 7F.

Decomposition:
- Shared package seg_pkg:
  - 16-entry active-low segment table constant;
  - SEG_OFF = 7'h7F;
  - MAX_HEX = 4'hF, MAX_DEC = 4'd9.
- Sub-module seg_digit_decode: nibble + blank in, 7-bit cathodes out. Combinational, reused by other display blocks.
- The per-digit up/down carry chain stays in this module as a generate loop.

Test Plan (DIGITS=4, TICK_DIV=4, SCAN_DIV=2 unless stated):
1. Assert RST mid-scan with Count=0x1234 -> Count=0, Anode=4'b1111, Out=7F in the same cycle, without waiting for CLK. After release, the first increment occurs 4 cycles later.
2. MODE=1, UP=1, LOAD_VAL=0x9999 loaded, EN=1 -> after 4 cycles Count=0x0000 and Wrap high for exactly one cycle. MODE=0 with 0xFFFF behaves the same way.
3. MODE=1, UP=0, load 0x0100 -> next tick gives Count=0x0099. Load 0x0000 -> next tick gives 0x9999 with a Wrap pulse.
4. LOAD and tick in the same cycle, LOAD_VAL=0x00AB, MODE=1 -> Count=0x0099 (clamped), not incremented; the next tick is 4 cycles later.
5. Count=0x0007, BLANK_LZ=1 -> Anode cycles 1110 only for digit 0 with Out=78; the slots for digits 1-3 show Anode=1111, Out=7F. With BLANK_LZ=0, those slots show Out=40.
6. EN=0 for 20 cycles -> Count and prescaler frozen while the scan keeps rotating 1110->1101->1011->0111 every 2 cycles.
